// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM sequencing a shared ALU/memory datapath
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       EQ,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUctrl,
    output logic [1:0] ImmSrc,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_IDLE = 3'b111;

    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_ERROR
    } state_t;

    state_t     state, state_nx;
    logic       funct3_ok;
    logic [2:0] alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_START;
        end else begin
            state <= state_nx;
        end
    end

    // Only the ALU funct3 values this core implements; everything else traps.
    assign funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                       (funct3 == 3'b110) || (funct3 == 3'b111);

    // funct7_5 selects sub only for register-register ops; there is no subi.
    always_comb begin
        alu_op = ALU_IDLE;
        case (funct3)
            3'b000:  alu_op = (funct7_5 && (opcode == OP_R)) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_IDLE;
        endcase
    end

    always_comb begin
        state_nx   = state;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUctrl    = ALU_IDLE;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase

        case (state)
            S_START: state_nx = S_FETCH;
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUctrl   = ALU_ADD;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_nx = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ALUctrl = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_nx = (funct3 == 3'b010) ? S_MEMADR : S_ERROR;
                    OP_R:         state_nx = funct3_ok ? S_EXECR : S_ERROR;
                    OP_I:         state_nx = funct3_ok ? S_EXECI : S_ERROR;
                    OP_BR:        state_nx = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ERROR;
                    OP_JAL:       state_nx = S_JAL;
                    default:      state_nx = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                ALUctrl  = ALU_ADD;
                state_nx = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) state_nx = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_nx   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_nx = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                ALUctrl  = alu_op;
                state_nx = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                ALUctrl  = alu_op;
                state_nx = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_nx   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUctrl    = ALU_SUB;
                ImmSrc     = 2'b10;
                PCWrite    = funct3[0] ^ EQ;
                instr_done = 1'b1;
                state_nx   = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                ALUctrl  = ALU_ADD;
                PCWrite  = 1'b1;
                state_nx = S_ALUWB;
            end
            S_ERROR: illegal = 1'b1;
            default: state_nx = S_ERROR;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller with directed instruction sequences
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       EQ;
    logic       mem_ready;
    logic       PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUctrl;
    logic       instr_done, illegal;

    int checks = 0;
    int fails  = 0;

    logic [18:0] exp_q[$];
    string       name_q[$];

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .EQ(EQ), .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUctrl(ALUctrl), .ImmSrc(ImmSrc),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Field order: PCWrite IRWrite AdrSrc MemRead MemWrite RegWrite ResultSrc ALUSrcA ALUSrcB ALUctrl ImmSrc instr_done illegal
    function automatic logic [18:0] mk(input logic pcw, input logic irw, input logic adr, input logic mrd,
                                       input logic mwr, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] alu,
                                       input logic [1:0] imm, input logic done, input logic ill);
        return {pcw, irw, adr, mrd, mwr, rw, rs, sa, sb, alu, imm, done, ill};
    endfunction

    // Monitor: the DUT presents a control word every cycle; compare it against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [18:0] act, e;
            string nm;
            act = {PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ALUctrl, ImmSrc, instr_done, illegal};
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act !== e) begin
                fails++;
                $display("FAIL %s: got %b expected %b", nm, act, e);
            end
            checks++;
            if (MemRead && MemWrite) begin
                fails++;
                $display("FAIL %s_rdwr_excl: got MemRead=1 MemWrite=1 expected not both", nm);
            end
        end
    end

    task automatic cyc(input logic [18:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    function automatic logic [18:0] e_start(input logic [1:0] imm);
        return mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b111,imm,0,0);
    endfunction
    function automatic logic [18:0] e_fetch(input logic r, input logic [1:0] imm);
        return mk(r,r,0,1,0,0,2'b10,2'b00,2'b10,3'b000,imm,0,0);
    endfunction
    function automatic logic [18:0] e_decode(input logic [1:0] imm);
        return mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,imm,0,0);
    endfunction
    function automatic logic [18:0] e_aluwb(input logic [1:0] imm);
        return mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b111,imm,1,0);
    endfunction

    task automatic do_reset(input logic [1:0] imm);
        rst_n = 1'b0;
        cyc(e_start(imm), "reset_hold");
        rst_n = 1'b1;
        cyc(e_start(imm), "start_after_release");
    endtask

    task automatic rtype(input logic [2:0] f3, input logic f7, input logic [2:0] alu, input string nm);
        set_instr(7'b0110011, f3, f7);
        mem_ready = 1'b1;
        cyc(e_fetch(1, 2'b00), {nm, "_fetch"});
        cyc(e_decode(2'b00), {nm, "_decode"});
        cyc(mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,alu,2'b00,0,0), {nm, "_execr"});
        cyc(e_aluwb(2'b00), {nm, "_aluwb"});
    endtask

    task automatic branch(input logic [2:0] f3, input logic eq, input logic taken, input string nm);
        set_instr(7'b1100011, f3, 1'b0);
        mem_ready = 1'b1;
        EQ        = eq;
        cyc(e_fetch(1, 2'b10), {nm, "_fetch"});
        cyc(e_decode(2'b10), {nm, "_decode"});
        cyc(mk(taken,0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,1,0), {nm, "_branch"});
    endtask

    initial begin
        rst_n = 1'b0;
        set_instr(7'b0010011, 3'b000, 1'b0);
        EQ        = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset(2'b00);

        // addi x1,x0,5
        cyc(e_fetch(1, 2'b00), "addi_fetch");
        cyc(e_decode(2'b00), "addi_decode");
        cyc(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0), "addi_execi");
        cyc(e_aluwb(2'b00), "addi_aluwb");

        // lw with 3 fetch stalls and 2 read stalls: 10 cycles
        set_instr(7'b0000011, 3'b010, 1'b0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(e_fetch(0, 2'b00), "lw_fetch_stall");
        mem_ready = 1'b1;
        cyc(e_fetch(1, 2'b00), "lw_fetch");
        cyc(e_decode(2'b00), "lw_decode");
        cyc(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0), "lw_memadr");
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) cyc(mk(0,0,1,1,0,0,2'b00,2'b00,2'b00,3'b111,2'b00,0,0), "lw_memrd_stall");
        mem_ready = 1'b1;
        cyc(mk(0,0,1,1,0,0,2'b00,2'b00,2'b00,3'b111,2'b00,0,0), "lw_memrd");
        cyc(mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,3'b111,2'b00,1,0), "lw_memwb");

        // branches
        branch(3'b001, 1'b0, 1'b1, "bne_taken");
        branch(3'b001, 1'b1, 1'b0, "bne_not");
        branch(3'b000, 1'b1, 1'b1, "beq_taken");
        branch(3'b000, 1'b0, 1'b0, "beq_not");

        // R-type ALU decode
        rtype(3'b000, 1'b1, 3'b001, "sub");
        rtype(3'b000, 1'b0, 3'b000, "add");
        rtype(3'b010, 1'b0, 3'b101, "slt");
        rtype(3'b111, 1'b0, 3'b010, "and");
        rtype(3'b110, 1'b0, 3'b011, "or");

        // I-type with funct7_5 set still adds
        set_instr(7'b0010011, 3'b000, 1'b1);
        cyc(e_fetch(1, 2'b00), "addi7_fetch");
        cyc(e_decode(2'b00), "addi7_decode");
        cyc(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0), "addi7_execi");
        cyc(e_aluwb(2'b00), "addi7_aluwb");

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        cyc(e_fetch(1, 2'b11), "jal_fetch");
        cyc(e_decode(2'b11), "jal_decode");
        cyc(mk(1,0,0,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0,0), "jal_jal");
        cyc(e_aluwb(2'b11), "jal_aluwb");

        // sw with one write stall
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc(e_fetch(1, 2'b01), "sw_fetch");
        cyc(e_decode(2'b01), "sw_decode");
        cyc(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0), "sw_memadr");
        mem_ready = 1'b0;
        cyc(mk(0,0,1,0,1,0,2'b00,2'b00,2'b00,3'b111,2'b01,0,0), "sw_memwr_stall");
        mem_ready = 1'b1;
        cyc(mk(0,0,1,0,1,0,2'b00,2'b00,2'b00,3'b111,2'b01,1,0), "sw_memwr");

        // reset asserted mid-MEMWR
        cyc(e_fetch(1, 2'b01), "sw2_fetch");
        cyc(e_decode(2'b01), "sw2_decode");
        cyc(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0), "sw2_memadr");
        mem_ready = 1'b0;
        cyc(mk(0,0,1,0,1,0,2'b00,2'b00,2'b00,3'b111,2'b01,0,0), "sw2_memwr_stall");
        rst_n = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_memwrite: got %b expected 0", MemWrite);
        end
        cyc(e_start(2'b01), "midreset_start");
        rst_n = 1'b1;
        cyc(e_start(2'b01), "midreset_release");
        cyc(e_fetch(0, 2'b01), "midreset_fetch");
        mem_ready = 1'b1;

        // lui is unsupported: terminal ERROR
        set_instr(7'b0110111, 3'b000, 1'b0);
        cyc(e_fetch(1, 2'b00), "lui_fetch");
        cyc(e_decode(2'b00), "lui_decode");
        for (int i = 0; i < 20; i++) begin
            EQ        = i[0];
            mem_ready = i[1];
            cyc(mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b111,2'b00,0,1), "lui_error");
        end
        mem_ready = 1'b1;
        do_reset(2'b00);

        // R-type with unsupported funct3
        set_instr(7'b0110011, 3'b001, 1'b0);
        cyc(e_fetch(1, 2'b00), "sll_fetch");
        cyc(e_decode(2'b00), "sll_decode");
        cyc(mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b111,2'b00,0,1), "sll_error");
        cyc(mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b111,2'b00,0,1), "sll_error_hold");
        do_reset(2'b00);

        // lw with bad funct3 traps
        set_instr(7'b0000011, 3'b000, 1'b0);
        cyc(e_fetch(1, 2'b00), "lb_fetch");
        cyc(e_decode(2'b00), "lb_decode");
        cyc(mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b111,2'b00,0,1), "lb_error");

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
